// File: rtl/dmem_target.sv
// Data-memory responder for the core's data port: 64-bit word array with a fixed number of wait states.
// Define DMEM_TARGET_BOUNDS_CHECK_EN to fault out-of-range accesses instead of wrapping the index.
module dmem_target #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [6:0]  data_write_mask_in,
  input  logic [63:0] data_write_value_in,
  output logic [63:0] data_read_value_out,
  output logic        data_ready_out,
  output logic        fault_out
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0]  LAST_CNT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [6:0]  mask_q, mask_d;
  logic [63:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;
  logic [63:0] rdata_q, rdata_d;

  logic [63:0] mem [DEPTH_WORDS];

  logic          req;
  logic          commit;
  logic          mem_we;
  logic [63:0]   acc_addr;
  logic [6:0]    acc_mask;
  logic [63:0]   acc_wdata;
  logic          acc_wr;
  logic [7:0]    acc_be;
  logic [AW-1:0] idx;
  logic          range_err;

  assign req = data_read_in | data_write_in;

  // With zero wait states the access commits on the accepting edge, so it must use the live inputs.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_addr  = data_address_in;
      acc_mask  = data_write_mask_in;
      acc_wdata = data_write_value_in;
      acc_wr    = data_write_in;
    end else begin
      acc_addr  = addr_q;
      acc_mask  = mask_q;
      acc_wdata = wdata_q;
      acc_wr    = wr_q;
    end
    acc_be = {acc_mask[6], acc_mask};
  end

`ifdef DMEM_TARGET_BOUNDS_CHECK_EN
  logic [63:0] word_off;

  always_comb begin
    word_off  = (acc_addr - BASE_ADDR) >> 3;
    range_err = (acc_addr < BASE_ADDR) || (word_off >= 64'(DEPTH_WORDS));
    idx       = word_off[AW-1:0];
  end
`else
  always_comb begin
    idx       = AW'((acc_addr - BASE_ADDR) >> 3);
    range_err = 1'b0;
  end
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = data_address_in;
          mask_d  = data_write_mask_in;
          wdata_d = data_write_value_in;
          wr_d    = data_write_in;
          cnt_d   = 4'd0;
          if (ZERO_WAIT) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        // Full deassertion is a pipeline flush: drop the access without committing it.
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = commit;
    fault_d = commit & range_err;
    rdata_d = rdata_q;
    if (commit) begin
      rdata_d = range_err ? 64'h0 : mem[idx];
    end
  end

  // rst_n gates the array write so a clock edge during reset can never commit an access.
  assign mem_we = commit & acc_wr & ~range_err & rst_n;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 64'h0;
      mask_q  <= 7'h0;
      wdata_q <= 64'h0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 64'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the word array has no reset; contents survive rst_n and start undefined.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (acc_be[b]) begin
          mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  assign data_read_value_out = rdata_q;
  assign data_ready_out      = ready_q;
  assign fault_out           = fault_q;

endmodule

// File: tb/tb_dmem_target.sv
// Self-checking bench for dmem_target: three instances (1, 0 and 3 wait states) against a word-array model.
// Honours DMEM_TARGET_BOUNDS_CHECK_EN the same way the design does.
module tb_dmem_target;

  logic        clk;
  logic        rst_n;
  logic [63:0] addr;
  logic        rd;
  logic        wr;
  logic [6:0]  mask;
  logic [63:0] wdata;
  int          sel;

  logic [63:0] rdata_o [3];
  logic        ready_o [3];
  logic        fault_o [3];

  logic [63:0] model [3][1024];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_target #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(64'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_address_in(addr),
    .data_read_in(rd && sel == 0), .data_write_in(wr && sel == 0),
    .data_write_mask_in(mask), .data_write_value_in(wdata),
    .data_read_value_out(rdata_o[0]), .data_ready_out(ready_o[0]), .fault_out(fault_o[0])
  );

  dmem_target #(.DEPTH_WORDS(16), .WAIT_STATES(0), .BASE_ADDR(64'h0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_address_in(addr),
    .data_read_in(rd && sel == 1), .data_write_in(wr && sel == 1),
    .data_write_mask_in(mask), .data_write_value_in(wdata),
    .data_read_value_out(rdata_o[1]), .data_ready_out(ready_o[1]), .fault_out(fault_o[1])
  );

  dmem_target #(.DEPTH_WORDS(8), .WAIT_STATES(3), .BASE_ADDR(64'h1000)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data_address_in(addr),
    .data_read_in(rd && sel == 2), .data_write_in(wr && sel == 2),
    .data_write_mask_in(mask), .data_write_value_in(wdata),
    .data_read_value_out(rdata_o[2]), .data_ready_out(ready_o[2]), .fault_out(fault_o[2])
  );

  function automatic int depth_of(input int d);
    case (d)
      0:       return 1024;
      1:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [63:0] base_of(input int d);
    return (d == 2) ? 64'h1000 : 64'h0;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete handshake on instance d, checked against the model, which is then updated.
  task automatic access(input int d, input logic rd_i, input logic wr_i, input logic [63:0] a,
                        input logic [6:0] m, input logic [63:0] wd, input string tag);
    logic [63:0] off, widx, exp_rd;
    logic        exp_fault;
    int          idx, n;
    off  = a - base_of(d);
    widx = off >> 3;
    idx  = int'(widx % 64'(depth_of(d)));
`ifdef DMEM_TARGET_BOUNDS_CHECK_EN
    exp_fault = (a < base_of(d)) || (widx >= 64'(depth_of(d)));
`else
    exp_fault = 1'b0;
`endif
    exp_rd = exp_fault ? 64'h0 : model[d][idx];

    @(negedge clk);
    sel = d; addr = a; mask = m; wdata = wd; rd = rd_i; wr = wr_i;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready_o[d] && n < 40);
    rd = 1'b0; wr = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(ws_of(d) + 1));
    check({tag, "_fault"}, 64'(fault_o[d]), 64'(exp_fault));
    if (rd_i) check({tag, "_rdata"}, rdata_o[d], exp_rd);

    if (wr_i && !exp_fault) begin
      for (int b = 0; b < 8; b++) begin
        if ((b < 6) ? m[b] : m[6]) model[d][idx][8*b +: 8] = wd[8*b +: 8];
      end
    end

    @(posedge clk); #1;
    check({tag, "_single_pulse"}, 64'(ready_o[d]), 64'h0);
    if (rd_i) check({tag, "_hold"}, rdata_o[d], exp_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0]  pat;
    logic [63:0] a;
    int          cnt, w, nwords, op;

    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; sel = 0;
    addr = 64'h0; mask = 7'h0; wdata = 64'h0;
    #3;
    for (int d = 0; d < 3; d++) begin
      check("reset_ready", 64'(ready_o[d]), 64'h0);
      check("reset_fault", 64'(fault_o[d]), 64'h0);
      check("reset_rdata", rdata_o[d], 64'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Give every word the random traffic can touch a known value.
    for (int d = 0; d < 3; d++) begin
      nwords = (d == 0) ? 32 : depth_of(d);
      for (int i = 0; i < nwords; i++) begin
        access(d, 1'b0, 1'b1, base_of(d) + 64'(i * 8), 7'h7F,
               {$urandom, $urandom} | 64'h1, "init");
      end
    end

    access(0, 1'b0, 1'b1, 64'h40, 7'h7F, 64'h1122334455667788, "wtr_wr");
    access(0, 1'b1, 1'b0, 64'h40, 7'h00, 64'h0, "wtr_rd");
    check("wtr_value", rdata_o[0], 64'h1122334455667788);

    access(0, 1'b0, 1'b1, 64'h48, 7'h7F, 64'h0, "lanes_clr");
    access(0, 1'b0, 1'b1, 64'h48, 7'b1000001, 64'hFFFF_FFFF_FFFF_FFFF, "lanes_wr");
    access(0, 1'b1, 1'b0, 64'h48, 7'h00, 64'h0, "lanes_rd");
    check("lanes_value", rdata_o[0], 64'hFFFF_0000_0000_00FF);

    access(0, 1'b1, 1'b0, 64'h2000, 7'h00, 64'h0, "bounds_hi");
    access(2, 1'b1, 1'b0, 64'h0FF8, 7'h00, 64'h0, "bounds_lo");
    access(0, 1'b1, 1'b1, 64'h50, 7'h0F, 64'hA5A5_A5A5_5A5A_5A5A, "rbw");

    // Read held high across two back-to-back requests with zero wait states.
    @(negedge clk);
    sel = 1; addr = 64'h0; rd = 1'b1; wr = 1'b0;
    pat = 4'h0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      pat[c] = ready_o[1];
      if (c == 0) begin
        check("b2b_data0", rdata_o[1], model[1][0]);
        addr = 64'h8;
      end
      if (c == 2) begin
        check("b2b_data1", rdata_o[1], model[1][1]);
        rd = 1'b0;
      end
    end
    check("b2b_ready_pattern", 64'(pat), 64'(4'b0101));

    // Flush: write dropped after one wait cycle must neither respond nor commit.
    @(negedge clk);
    sel = 2; addr = 64'h1010; mask = 7'h7F; wdata = 64'hDEAD_BEEF_0BAD_F00D; rd = 1'b0; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    cnt = (ready_o[2] == 1'b1) ? 1 : 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready_o[2]) cnt++;
    end
    check("flush_no_ready", 64'(cnt), 64'h0);
    access(2, 1'b1, 1'b0, 64'h1010, 7'h00, 64'h0, "flush_rd");

    // Reset in the middle of a write's wait states.
    access(2, 1'b1, 1'b0, 64'h1008, 7'h00, 64'h0, "pre_rst_rd");
    @(negedge clk);
    sel = 2; addr = 64'h1008; mask = 7'h7F; wdata = 64'h0123_4567_89AB_CDEF; wr = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready_o[2]), 64'h0);
    check("rst_mid_rdata", rdata_o[2], 64'h0);
    repeat (3) @(posedge clk);
    wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    access(2, 1'b1, 1'b0, 64'h1008, 7'h00, 64'h0, "post_rst_rd");

    for (int d = 0; d < 3; d++) begin
      nwords = (d == 0) ? 32 : depth_of(d);
      for (int k = 0; k < 30; k++) begin
        w = int'($urandom_range(nwords - 1));
        if ($urandom_range(7) == 0) begin
          if (d == 2) a = base_of(d) - 64'(8 * (1 + $urandom_range(3)));
          else        a = base_of(d) + 64'((depth_of(d) + w) * 8);
        end else begin
          a = base_of(d) + 64'(w * 8);
        end
        a[2:0] = 3'($urandom_range(7));
        op = int'($urandom_range(2));
        access(d, op != 1, op != 0, a, 7'($urandom), {$urandom, $urandom}, "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
